// File: rtl/pong_pkg.sv
// Shared types and constants for the paddle front-end.
package pong_pkg;

  // Game control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } game_state_t;

  // Bit positions inside the 4-bit key vectors
  localparam int KEY_DOWN  = 0;
  localparam int KEY_UP    = 1;
  localparam int KEY_START = 2;
  localparam int KEY_RST   = 3;
  localparam int NUM_KEYS  = 4;

  // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit)
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-bit push-button conditioner: 2-flop synchroniser followed by a
// stability counter. The debounced output only follows the synchronised
// input after it has differed for DEB_CYCLES consecutive cycles.
module key_debounce
  import pong_pkg::*;
#(
  parameter int DEB_CYCLES = 250000
) (
  input  logic VGA_CLK,
  input  logic reset,
  input  logic raw,
  output logic deb
);

  localparam int              CW       = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  // Two-stage synchroniser; idles at the released (high) level
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Stability counter: any agreement restarts it, the last count commits the new level
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      deb <= 1'b1;
    end else if (sync_b == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      deb <= sync_b;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/paddle_key_ctrl.sv
// Paddle input front-end: debounces the four active-low buttons, generates
// the move_clock pacing square wave, runs the IDLE/PLAY/PAUSE game state
// machine and stretches the game reset so the paddle is sure to see it.
//
// Build option: define MOVE_ACCEL_EN to add key-hold acceleration, which
// halves the move_clock half-period after ACCEL_HOLD move_clock periods of a
// single direction key held in PLAY.
module paddle_key_ctrl
  import pong_pkg::*;
#(
  parameter int DEB_CYCLES = 250000,
  parameter int MOVE_HALF  = 312500
`ifdef MOVE_ACCEL_EN
  ,
  parameter int ACCEL_HOLD = 20
`endif
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic [3:0] key_raw,
  output logic [3:0] key,
  output logic       move_clock,
  output logic       start,
  output logic       game_reset
);

  localparam int               DIV_W     = cnt_width(MOVE_HALF);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(MOVE_HALF - 1);

  // ------------------------------------------------------------------
  // Key conditioning
  // ------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_deb;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .VGA_CLK (VGA_CLK),
      .reset   (reset),
      .raw     (key_raw[i]),
      .deb     (key_deb[i])
    );
  end

  // Previous debounced level of the two control keys, for press detection
  logic start_prev;
  logic rst_prev;
  logic press_start;
  logic press_rst;

  // Delay the control keys by one cycle to find their falling edges
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      start_prev <= 1'b1;
      rst_prev   <= 1'b1;
    end else begin
      start_prev <= key_deb[KEY_START];
      rst_prev   <= key_deb[KEY_RST];
    end
  end

  // A press is the debounced 1->0 transition, high for exactly one cycle
  assign press_start = start_prev & ~key_deb[KEY_START];
  assign press_rst   = rst_prev   & ~key_deb[KEY_RST];

  // ------------------------------------------------------------------
  // Game state machine
  // ------------------------------------------------------------------
  game_state_t state;
  game_state_t state_next;
  logic        freeze;

  // State register
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; the game reset key overrides start/pause
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    if (press_rst) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (press_start) state_next = PLAY;
        PLAY:    if (press_start) state_next = PAUSE;
        PAUSE:   if (press_start) state_next = PLAY;
        default: state_next = IDLE;
      endcase
    end
  end

  // State outputs: running flag and direction freeze while paused
  always_comb begin
    start  = 1'b0;
    freeze = 1'b0;
    unique case (state)
      IDLE:    ;
      PLAY:    start = 1'b1;
      PAUSE: begin
        start  = 1'b1;
        freeze = 1'b1;
      end
      default: ;
    endcase
  end

  // Direction keys are released (high) while paused; control keys always pass
  assign key = {key_deb[KEY_RST], key_deb[KEY_START],
                freeze ? 2'b11 : key_deb[KEY_UP:KEY_DOWN]};

  // ------------------------------------------------------------------
  // move_clock divider
  // ------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_last;
  logic             div_wrap;

  // A >= compare lets a shortened or restored terminal take effect cleanly
  assign div_wrap = (div_cnt >= div_last);

  // Free-running divider; move_clock toggles on every wrap
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      move_clock <= 1'b0;
    end else if (div_wrap) begin
      div_cnt    <= '0;
      move_clock <= ~move_clock;
    end else begin
      div_cnt    <= div_cnt + 1'b1;
    end
  end

`ifdef MOVE_ACCEL_EN
  // ------------------------------------------------------------------
  // Key-hold acceleration
  // ------------------------------------------------------------------
  localparam int               FAST_HALF = (MOVE_HALF / 2 > 0) ? MOVE_HALF / 2 : 1;
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_HALF - 1);
  localparam int               HOLD_W    = cnt_width(ACCEL_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ACCEL_HOLD);

  logic              move_rise;
  logic              one_dir;
  logic [HOLD_W-1:0] hold_cnt;

  // move_clock is about to go 0->1 on this edge
  assign move_rise = div_wrap & ~move_clock;
  // Exactly one direction key held while the game is running
  assign one_dir   = (state == PLAY) & (key_deb[KEY_UP] ^ key_deb[KEY_DOWN]);

  // Count move_clock periods of a steady single-direction hold, saturating
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (!one_dir) begin
      hold_cnt <= '0;
    end else if (move_rise && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign div_last = (hold_cnt == HOLD_MAX) ? FAST_LAST : HALF_LAST;
`else
  assign div_last = HALF_LAST;
`endif

  // ------------------------------------------------------------------
  // Game reset stretcher
  // ------------------------------------------------------------------
  logic move_prev;

  // One-cycle delayed move_clock, to see the cycle right after its rise
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) move_prev <= 1'b0;
    else       move_prev <= move_clock;
  end

  // Hold the reset request until the paddle has seen one move_clock rise
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      game_reset <= 1'b1;
    end else if (press_rst) begin
      game_reset <= 1'b1;
    end else if (move_clock && !move_prev) begin
      game_reset <= 1'b0;
    end
  end

endmodule

// File: tb/tb_paddle_key_ctrl.sv
// Directed self-checking bench for paddle_key_ctrl with DEB_CYCLES=4,
// MOVE_HALF=3, ACCEL_HOLD=2. Honours MOVE_ACCEL_EN for the speed check.
module tb_paddle_key_ctrl;

  logic       VGA_CLK;
  logic       reset;
  logic [3:0] key_raw;
  logic [3:0] key;
  logic       move_clock;
  logic       start;
  logic       game_reset;

  int checks   = 0;
  int failures = 0;

`ifdef MOVE_ACCEL_EN
  localparam int EXP_HELD_HALF = 1;
`else
  localparam int EXP_HELD_HALF = 3;
`endif

  paddle_key_ctrl #(
    .DEB_CYCLES (4),
    .MOVE_HALF  (3)
`ifdef MOVE_ACCEL_EN
    ,
    .ACCEL_HOLD (2)
`endif
  ) dut (
    .VGA_CLK    (VGA_CLK),
    .reset      (reset),
    .key_raw    (key_raw),
    .key        (key),
    .move_clock (move_clock),
    .start      (start),
    .game_reset (game_reset)
  );

  initial VGA_CLK = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge VGA_CLK);
      #1;
    end
  endtask

  // Cycles until key[idx] reads low, -1 on timeout
  task automatic wait_key_low(input int idx, output int lat);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (key[idx] === 1'b0) begin
        lat = i;
        break;
      end
    end
  endtask

  // Length in cycles of the next complete move_clock half-period, -1 on timeout
  task automatic measure_half(output int len);
    logic m0;
    int   n;
    len = -1;
    m0  = move_clock;
    for (int i = 0; i < 20 && move_clock === m0; i++) tick(1);
    if (move_clock !== m0) begin
      m0 = move_clock;
      n  = 0;
      for (int i = 0; i < 20; i++) begin
        tick(1);
        n++;
        if (move_clock !== m0) begin
          len = n;
          break;
        end
      end
    end
  endtask

  // Hold one raw key low long enough to debounce, then release it
  task automatic press_key(input int idx);
    key_raw[idx] = 1'b0;
    tick(8);
    key_raw[idx] = 1'b1;
    tick(8);
  endtask

  initial begin
    int         lat;
    int         half;
    int         idx;
    int         rise_idx;
    int         fall_idx;
    logic       pmc;
    logic [3:0] acc;

    // ---- 1: reset values and free-running divider ----
    reset   = 1'b1;
    key_raw = 4'b1111;
    tick(3);
    check("rst_key",        key,        4'b1111);
    check("rst_move_clock", move_clock, 1'b0);
    check("rst_start",      start,      1'b0);
    check("rst_game_reset", game_reset, 1'b1);
    reset = 1'b0;
    tick(2);
    check("pre_rise_mc", move_clock, 1'b0);
    check("pre_rise_gr", game_reset, 1'b1);
    tick(1);
    check("first_rise_mc", move_clock, 1'b1);
    check("first_rise_gr", game_reset, 1'b1);
    tick(1);
    check("gr_cleared", game_reset, 1'b0);
    tick(2);
    check("first_fall_mc", move_clock, 1'b0);
    measure_half(half);
    check("idle_half", half, 3);

    // ---- 2: debounce glitch rejection and latency ----
    key_raw[0] = 1'b0;
    tick(3);
    key_raw[0] = 1'b1;
    acc = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      acc = acc & key;
    end
    check("glitch_no_change", acc, 4'b1111);
    key_raw[0] = 1'b0;
    wait_key_low(0, lat);
    check("deb_latency", lat, 6);
    key_raw[0] = 1'b1;
    tick(8);
    check("deb_release", key, 4'b1111);

    // ---- 3: start / pause / resume ----
    press_key(2);
    check("play_start", start, 1'b1);
    press_key(2);
    check("pause_start", start, 1'b1);
    key_raw[1] = 1'b0;
    tick(10);
    check("pause_masked_key", key, 4'b1111);
    press_key(2);
    check("resume_start", start, 1'b1);
    check("resume_key", key, 4'b1101);

    // ---- 6: held direction key sets the move speed ----
    tick(20);
    measure_half(half);
    check("held_half", half, EXP_HELD_HALF);
    key_raw[1] = 1'b1;
    tick(10);
    check("released_key", key, 4'b1111);
    measure_half(half);
    check("released_half", half, 3);

    // ---- 4: game reset key during PLAY ----
    key_raw[3] = 1'b0;
    lat      = -1;
    rise_idx = -1;
    fall_idx = -1;
    idx      = 0;
    for (int i = 0; i < 30; i++) begin
      pmc = move_clock;
      tick(1);
      idx++;
      if (move_clock === 1'b1 && pmc === 1'b0) rise_idx = idx;
      if (game_reset === 1'b1) begin
        lat = idx;
        break;
      end
    end
    check("gr_set_latency", lat, 7);
    check("gr_start_low", start, 1'b0);
    for (int i = 0; i < 30; i++) begin
      pmc = move_clock;
      tick(1);
      idx++;
      if (move_clock === 1'b1 && pmc === 1'b0) rise_idx = idx;
      if (game_reset === 1'b0) begin
        fall_idx = idx;
        break;
      end
    end
    check("gr_clears_after_rise", fall_idx - rise_idx, 1);
    key_raw[3] = 1'b1;
    tick(8);

    // Simultaneous start and reset presses: reset wins
    press_key(2);
    check("replay_start", start, 1'b1);
    key_raw[3:2] = 2'b00;
    tick(10);
    check("both_start_low", start, 1'b0);
    key_raw[3:2] = 2'b11;
    tick(8);
    check("both_after_release", start, 1'b0);
    press_key(2);
    check("idle_to_play", start, 1'b1);

    // ---- 5: async reset in the middle of a debounce ----
    key_raw[1] = 1'b0;
    tick(4);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_key",        key,        4'b1111);
    check("mid_rst_move_clock", move_clock, 1'b0);
    check("mid_rst_start",      start,      1'b0);
    check("mid_rst_game_reset", game_reset, 1'b1);
    tick(2);
    reset = 1'b0;
    wait_key_low(1, lat);
    check("restart_latency", lat, 6);
    key_raw[1] = 1'b1;
    tick(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
